// File: rtl/dlx_pkg.sv
// Shared types for the DLX hazard controller: pipeline stage entries and
// operand-forwarding selector codes.
package dlx_pkg;

    localparam int NREG_W = 5;

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rd;
        logic              we;
        logic              load;
    } stage_entry_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // r0 is hard-wired zero, so an entry targeting it never produces a value.
    function automatic logic is_writing(stage_entry_t e);
        return e.valid && e.we && (e.rd != '0);
    endfunction

endpackage

// File: rtl/dlx_fwd_match.sv
// Per-source operand match: selects the youngest in-flight producer of rs
// and flags a load in EX that the consumer cannot yet receive.
module dlx_fwd_match
    import dlx_pkg::*;
(
    input  logic [NREG_W-1:0] rs,
    input  logic              used,
    input  stage_entry_t      ex_e,
    input  stage_entry_t      mem_e,
    input  stage_entry_t      wb_e,
    output fwd_sel_e          sel,
    output logic              load_hit
);

    logic src_ok;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;
    logic unused_load;

    assign src_ok  = used && (rs != '0);
    assign hit_ex  = src_ok && is_writing(ex_e)  && (ex_e.rd  == rs);
    assign hit_mem = src_ok && is_writing(mem_e) && (mem_e.rd == rs);
    assign hit_wb  = src_ok && is_writing(wb_e)  && (wb_e.rd  == rs);

    // Load results exist only from MEM onward; MEM and WB loads forward normally.
    assign unused_load = mem_e.load ^ wb_e.load;

    always_comb begin
        sel = FWD_REG;
        if (hit_ex) begin
            sel = FWD_EX;
        end else if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

    assign load_hit = hit_ex && ex_e.load;

endmodule

// File: rtl/dlx_hazard_ctrl.sv
// DLX pipeline hazard controller: tracks EX/MEM/WB destinations, stalls on
// load-use, selects bypass sources and drives the register-file write port.
module dlx_hazard_ctrl
    import dlx_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs1,
    input  logic [NREG_W-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [NREG_W-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd1,
    output logic [1:0]        fwd2,
    output logic              wb_en,
    output logic [NREG_W-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_entry_t ex_e;
    stage_entry_t mem_e;
    stage_entry_t wb_e;
    stage_entry_t ex_next;
    fwd_sel_e     sel1;
    fwd_sel_e     sel2;
    logic         load_hit1;
    logic         load_hit2;

    dlx_fwd_match u_match1 (
        .rs       (id_rs1),
        .used     (id_valid && id_use1),
        .ex_e     (ex_e),
        .mem_e    (mem_e),
        .wb_e     (wb_e),
        .sel      (sel1),
        .load_hit (load_hit1)
    );

    dlx_fwd_match u_match2 (
        .rs       (id_rs2),
        .used     (id_valid && id_use2),
        .ex_e     (ex_e),
        .mem_e    (mem_e),
        .wb_e     (wb_e),
        .sel      (sel2),
        .load_hit (load_hit2)
    );

    assign stall = load_hit1 || load_hit2;
    assign fwd1  = sel1;
    assign fwd2  = sel2;
    assign wb_en = is_writing(wb_e);
    assign wb_rd = wb_e.rd;

    // Bubbles are fully zeroed so an empty WB slot presents rd=0.
    always_comb begin
        ex_next = '0;
        if (id_valid && !stall && !flush) begin
            ex_next.valid = 1'b1;
            ex_next.rd    = id_rd;
            ex_next.we    = id_we;
            ex_next.load  = id_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_e      <= '0;
            mem_e     <= '0;
            wb_e      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_e  <= ex_next;
            mem_e <= ex_e;
            wb_e  <= mem_e;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Bench for dlx_hazard_ctrl: directed scenarios plus random traffic checked
// against an issue-history model that derives hazards from producer distance.
module tb_dlx_hazard_ctrl;
    import dlx_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use1;
    logic        id_use2;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_load;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd1;
    logic [1:0]  fwd2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [15:0] stall_cnt;
    logic        stall_s;
    logic [1:0]  fwd1_s;
    logic [1:0]  fwd2_s;
    logic        wb_en_s;
    logic [4:0]  wb_rd_s;
    logic [1:0]  stall_cnt_s;

    dlx_hazard_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
        .stall(stall), .fwd1(fwd1), .fwd2(fwd2), .wb_en(wb_en), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt)
    );

    dlx_hazard_ctrl #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
        .stall(stall_s), .fwd1(fwd1_s), .fwd2(fwd2_s), .wb_en(wb_en_s), .wb_rd(wb_rd_s),
        .stall_cnt(stall_cnt_s)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int         cyc;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } issued_t;

    issued_t hist[$];
    int      now;
    int      cnt16;
    int      cnt2;
    bit      known;
    int      exp_fwd1;
    int      exp_fwd2;
    bit      exp_stall;
    bit      exp_issue;
    bit      exp_wb_en;
    logic [4:0] exp_wb_rd;
    int      errors;
    int      checks;

    // Distance (1..3) to the youngest writer of rs, 0 when none.
    function automatic int dist_of(logic [4:0] rs, logic used, output bit is_load);
        is_load = 1'b0;
        if (!used || rs == 5'd0) return 0;
        for (int d = 1; d <= 3; d++) begin
            foreach (hist[i]) begin
                if (hist[i].cyc == now - d && hist[i].we && hist[i].rd == rs) begin
                    is_load = hist[i].load;
                    return d;
                end
            end
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic present(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic [4:0] rd,
                           input logic we, input logic ld, input logic fl, input logic rst);
        bit l1;
        bit l2;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2;
        id_rd = rd; id_we = we; id_load = ld; flush = fl; reset = rst;
        #1;
        exp_fwd1  = dist_of(rs1, v && u1, l1);
        exp_fwd2  = dist_of(rs2, v && u2, l2);
        exp_stall = (exp_fwd1 == 1 && l1) || (exp_fwd2 == 1 && l2);
        exp_issue = v && !exp_stall && !fl && !rst;
        exp_wb_en = 1'b0;
        exp_wb_rd = 5'd0;
        foreach (hist[i]) begin
            if (hist[i].cyc == now - 3 && hist[i].we && hist[i].rd != 5'd0) begin
                exp_wb_en = 1'b1;
                exp_wb_rd = hist[i].rd;
            end
        end
        if (known) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("stall_sat", 32'(stall_s), 32'(exp_stall));
            check("wb_en", 32'(wb_en), 32'(exp_wb_en));
            if (exp_wb_en) check("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
            if (!exp_stall) begin
                check("fwd1", 32'(fwd1), 32'(exp_fwd1));
                check("fwd2", 32'(fwd2), 32'(exp_fwd2));
            end
            check("stall_cnt", 32'(stall_cnt), 32'(cnt16));
            check("stall_cnt_sat", 32'(stall_cnt_s), 32'(cnt2));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            hist.delete();
            cnt16 = 0;
            cnt2  = 0;
            known = 1'b1;
        end else begin
            if (exp_issue) hist.push_back('{now, id_rd, id_we, id_load});
            if (exp_stall) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt2 < 3) cnt2++;
            end
        end
        now++;
        while (hist.size() > 0 && hist[0].cyc < now - 3) void'(hist.pop_front());
    endtask

    task automatic nop(input logic rst);
        present(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rst);
        advance();
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        present(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd);
        present(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       v, u1, u2, we, ld, fl, rst;
        logic [4:0] rs1, rs2, rd;
        errors = 0; checks = 0; now = 0; cnt16 = 0; cnt2 = 0; known = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
        id_rd = '0; id_we = 1'b0; id_load = 1'b0; flush = 1'b0; reset = 1'b1;

        // Reset held two cycles with a valid instruction in ID.
        for (int i = 0; i < 2; i++) begin
            present(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
            if (known) begin
                check("rst_stall", 32'(stall), 32'd0);
                check("rst_fwd1", 32'(fwd1), 32'd0);
                check("rst_fwd2", 32'(fwd2), 32'd0);
                check("rst_wb_en", 32'(wb_en), 32'd0);
                check("rst_wb_rd", 32'(wb_rd), 32'd0);
                check("rst_cnt", 32'(stall_cnt), 32'd0);
            end
            advance();
        end

        // ALU chain r3 -> r4 -> r5 -> r6.
        alu(5'd3, 5'd1, 5'd2); advance();
        alu(5'd4, 5'd3, 5'd3);
        check("alu_n1_fwd1", 32'(fwd1), 32'd1);
        check("alu_n1_fwd2", 32'(fwd2), 32'd1);
        advance();
        alu(5'd5, 5'd3, 5'd4);
        check("alu_n2_fwd1", 32'(fwd1), 32'd2);
        check("alu_n2_fwd2", 32'(fwd2), 32'd1);
        advance();
        alu(5'd6, 5'd3, 5'd0);
        check("alu_n3_fwd1", 32'(fwd1), 32'd3);
        check("alu_n3_fwd2", 32'(fwd2), 32'd0);
        check("alu_n3_wb", 32'(wb_rd), 32'd3);
        advance();
        alu(5'd7, 5'd3, 5'd3);
        check("alu_n4_fwd1", 32'(fwd1), 32'd0);
        advance();
        nop(1'b1);

        // Load-use: one stall cycle, then MEM forward.
        lw(5'd7);
        alu(5'd8, 5'd7, 5'd2);
        check("lu_stall", 32'(stall), 32'd1);
        advance();
        alu(5'd8, 5'd7, 5'd2);
        check("lu_stall_off", 32'(stall), 32'd0);
        check("lu_fwd1", 32'(fwd1), 32'd2);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        advance();

        // r0 destination and unused source never hazard.
        lw(5'd0);
        alu(5'd9, 5'd0, 5'd0);
        check("r0_stall", 32'(stall), 32'd0);
        check("r0_fwd1", 32'(fwd1), 32'd0);
        advance();
        nop(1'b0);
        present(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r0_wb_en", 32'(wb_en), 32'd0);
        advance();
        lw(5'd5);
        present(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("nouse_stall", 32'(stall), 32'd0);
        check("nouse_fwd2", 32'(fwd2), 32'd0);
        advance();

        // Flushed producer never forwards or writes back.
        present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        advance();
        alu(5'd12, 5'd10, 5'd10);
        check("fl_fwd1", 32'(fwd1), 32'd0);
        advance();
        nop(1'b0);
        present(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fl_wb_en", 32'(wb_en), 32'd0);
        advance();
        nop(1'b0);

        // Reset while MEM holds a write to r11.
        alu(5'd11, 5'd1, 5'd2); advance();
        nop(1'b0);
        nop(1'b1);
        for (int i = 0; i < 3; i++) begin
            present(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("rstmid_wb_en", 32'(wb_en), 32'd0);
            advance();
        end

        // Five load-use stalls saturate the 2-bit counter.
        nop(1'b1);
        for (int i = 0; i < 5; i++) begin
            lw(5'd7);
            alu(5'd8, 5'd7, 5'd7); advance();
            alu(5'd8, 5'd7, 5'd7); advance();
        end
        present(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_cnt2", 32'(stall_cnt_s), 32'd3);
        check("sat_cnt16", 32'(stall_cnt), 32'd5);
        advance();

        // Random traffic over a small register window to provoke hazards.
        v = 1'b0; rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0; rd = '0; we = 1'b0; ld = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(exp_stall && !fl)) begin
                v   = ($urandom_range(0, 7) != 0);
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                u1  = 1'($urandom);
                u2  = 1'($urandom);
                rd  = 5'($urandom_range(0, 7));
                we  = ($urandom_range(0, 3) != 0);
                ld  = ($urandom_range(0, 3) == 0);
            end
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            present(v, rs1, rs2, u1, u2, rd, we, ld, fl, rst);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlx_hazard_ctrl.md
# dlx_hazard_ctrl

Pipeline hazard controller for the DLX integer pipeline. It sequences access to the 32×32 register file. It tracks destination registers in flight in EX, MEM and WB, stalls decode on load-use hazards, and selects operand bypass sources for the two read ports. The register file has no write-through, so a value being written in the same cycle is not visible on S1/S2; this block must cover that case by forwarding from WB.

## Interface
Parameters
- NREG_W, 5, register-number width
- CNT_W, 16, stall-counter width

Ports
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1 / id_rs2  in  NREG_W  source register numbers (same encoding as register-file Rs1/Rs2)
- id_use1 / id_use2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  NREG_W  destination register
- id_we  in  1  instruction writes rd
- id_load  in  1  instruction is a load (result available only at end of MEM)
- flush  in  1  squash the instruction in ID (taken branch/jump)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd1 / fwd2  out  2  operand source for S1 / S2: 0 regfile, 1 EX ALU result, 2 MEM result, 3 WB write data (reg_s)
- wb_en  out  1  drives register-file WB
- wb_rd  out  NREG_W  drives register-file Rd
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Three stage entries: EX, MEM, WB. Each entry is {valid, rd, we, load}. An entry is "writing" iff valid & we & rd≠0.
- Shift on every clock edge: WB←MEM, MEM←EX.
- EX←ID fields when id_valid & ~stall & ~flush; otherwise EX gets a bubble (valid=0).
- Hazard match for source s (s∈{1,2}): id_valid & id_use_s & id_rs_s≠0 & the stage is writing & stage.rd==id_rs_s.
- Register 0 never matches, never forwards and is never written; wb_en=0 when WB.rd==0.
- stall = EX match on either source where EX.load=1. Combinational from the current entries. Lasts exactly one cycle per load-use pair, because the load moves to MEM and is then forwarded with code 2.
- fwd_s priority is EX(1) > MEM(2) > WB(3) > regfile(0), so the youngest producer wins.
- While stall=1, fwd1/fwd2 are don't-care; the bench must not check them.
- flush and stall together: flush wins and EX gets a bubble. The stall counter still increments if stall is asserted.
- wb_en = WB writing; wb_rd = WB.rd.
- stall_cnt increments by 1 on every cycle with stall=1 and saturates at 2^CNT_W−1.

## Timing
- Reset clears all entry valid bits and stall_cnt. Outputs after reset: stall=0, fwd1=fwd2=0, wb_en=0, wb_rd=0, stall_cnt=0.
- Reset asserted mid-operation discards all in-flight entries on that edge; no WB write is issued afterwards.
- stall, fwd1, fwd2, wb_en, wb_rd are combinational from registered state plus ID inputs. There is no added latency.
- Producer-to-consumer distance:
  - back-to-back ALU: fwd=1
  - distance 2: fwd=2
  - distance 3: fwd=3 (same cycle as the regfile write)
  - distance ≥4: fwd=0
- Load followed immediately by a user: 1 stall cycle, then fwd=2.

## Structure
- Shared package dlx_pkg holds:
  - typedef stage_entry_t {valid, rd, we, load}
  - enum fwd_sel_e {FWD_REG, FWD_EX, FWD_MEM, FWD_WB}
  - localparam NREG_W=5
- One natural sub-module: dlx_fwd_match. It is combinational and instantiated twice, once per source. Inputs are rs, use and the three entries; outputs are fwd_sel_e and load_hit.
- Stage registers, shift logic and the counter live in the top.

## Test plan
- Reset: hold reset 2 cycles with id_valid=1 → stall=0, fwd=0/0, wb_en=0, stall_cnt=0.
- ALU chain:
  - stimulus: ADD r3 (cycle n), SUB r4←r3,r3 (n+1), OR r5←r3,r4 (n+2), AND r6←r3,r0 (n+3)
  - response: n+1 fwd1=fwd2=1; n+2 fwd1=2, fwd2=1; n+3 fwd1=3, fwd2=0
- Load-use:
  - stimulus: LW r7 then ADD r8←r7,r2
  - response: one cycle stall=1 with bubble into EX; next cycle stall=0, fwd1=2; stall_cnt=1
- r0 and unused source:
  - stimulus: LW r0 then ADD r9←r0; separately LW r5 then an instruction with rs2=r5 but id_use2=0
  - response: no stall, fwd=0, wb_en never asserted for r0
- Flush:
  - stimulus: ADD r10 issued with flush=1, then a user of r10
  - response: fwd=0 and no WB of r10 three cycles later
- Reset mid-flight and saturation:
  - stimulus: reset while MEM holds a write to r11
  - response: wb_en=0 on following cycles
  - stimulus: CNT_W=2 with 5 consecutive stalls
  - response: stall_cnt=3
